// File: rtl/l1_mem_req_sched_pkg.sv
// Shared widths and the request payload type for the L1 memory request scheduler.
package l1_mem_req_sched_pkg;

  localparam int XLEN               = 32;
  localparam int DCACHE_BLOCKWORDS  = 2;
  localparam int BYTESOFWORD        = 4;
  localparam int A_SOURCE           = 3;
  localparam int NUM_CACHE_IN_SM    = 2;
  localparam int NUM_CACHE_DEPTH    = 1;
  localparam int D_SOURCE           = NUM_CACHE_DEPTH + A_SOURCE;
  localparam int L1_MAX_OUTSTANDING = 4;

  localparam int DATA_W = DCACHE_BLOCKWORDS * XLEN;
  localparam int MASK_W = DCACHE_BLOCKWORDS * BYTESOFWORD;

  // One TileLink-A request as held in the output slot (cache-local source only).
  typedef struct packed {
    logic [2:0]          opcode;
    logic [2:0]          param;
    logic [XLEN-1:0]     addr;
    logic [DATA_W-1:0]   data;
    logic [MASK_W-1:0]   mask;
    logic [A_SOURCE-1:0] source;
  } a_req_t;

endpackage

// File: rtl/l1_mem_req_sched_rr_arb.sv
// Combinational round-robin arbiter: first set request at or after ptr_i, wrapping.
module rr_arb
  import l1_mem_req_sched_pkg::*;
#(
  parameter int N   = 2,
  parameter int IDW = 1
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] idx_o,
  output logic           any_o
);

  // Scan N positions starting at the pointer; the first requester found wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (int'(ptr_i) + k) % N;
      if (!any_o && req_i[c[IDW-1:0]]) begin
        any_o               = 1'b1;
        gnt_o[c[IDW-1:0]]   = 1'b1;
        idx_o               = c[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/l1_mem_req_sched.sv
// Round-robin, credit-limited scheduler sharing one L2 request channel among L1 caches.
module l1_mem_req_sched
  import l1_mem_req_sched_pkg::*;
#(
  parameter int NUM_REQ         = NUM_CACHE_IN_SM,
  parameter int ID_W            = NUM_CACHE_DEPTH,
  parameter int MAX_OUTSTANDING = L1_MAX_OUTSTANDING,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            mem_req_in_valid_i,
  output logic [NUM_REQ-1:0]            mem_req_in_ready_o,
  input  logic [NUM_REQ*3-1:0]          mem_req_in_a_opcode_i,
  input  logic [NUM_REQ*3-1:0]          mem_req_in_a_param_i,
  input  logic [NUM_REQ*XLEN-1:0]       mem_req_in_a_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]     mem_req_in_a_data_i,
  input  logic [NUM_REQ*MASK_W-1:0]     mem_req_in_a_mask_i,
  input  logic [NUM_REQ*A_SOURCE-1:0]   mem_req_in_a_source_i,
  output logic                          mem_req_out_valid_o,
  input  logic                          mem_req_out_ready_i,
  output logic [2:0]                    mem_req_out_a_opcode_o,
  output logic [2:0]                    mem_req_out_a_param_o,
  output logic [XLEN-1:0]               mem_req_out_a_addr_o,
  output logic [DATA_W-1:0]             mem_req_out_a_data_o,
  output logic [MASK_W-1:0]             mem_req_out_a_mask_o,
  output logic [ID_W+A_SOURCE-1:0]      mem_req_out_a_source_o,
  input  logic                          mem_rsp_fire_i,
  input  logic [ID_W-1:0]               mem_rsp_src_id_i,
  output logic                          credit_underflow_o
);

  logic [NUM_REQ-1:0] elig, gnt;
  logic [ID_W-1:0]    win;
  logic               any, ld, accept, rsp_bad;
  a_req_t             sel;

  logic               out_valid_q, out_valid_d;
  a_req_t             slot_q, slot_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   cnt_q [NUM_REQ];
  logic [CNT_W-1:0]   cnt_d [NUM_REQ];
  logic               uf_q, uf_d;

  // A cache may compete only while it holds a free credit.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++)
      elig[i] = mem_req_in_valid_i[i] && (cnt_q[i] < CNT_W'(MAX_OUTSTANDING));
  end

  rr_arb #(.N(NUM_REQ), .IDW(ID_W)) u_arb (
    .req_i (elig),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (win),
    .any_o (any)
  );

  // Slot refills in the same cycle it drains.
  assign ld                 = !out_valid_q || mem_req_out_ready_i;
  assign accept             = ld && any;
  assign mem_req_in_ready_o = ld ? gnt : '0;
  assign rsp_bad            = 32'(mem_rsp_src_id_i) >= 32'(NUM_REQ);

  // Mux the winner's payload out of the flattened input buses.
  always_comb begin
    sel        = '0;
    sel.opcode = mem_req_in_a_opcode_i[3*win +: 3];
    sel.param  = mem_req_in_a_param_i[3*win +: 3];
    sel.addr   = mem_req_in_a_addr_i[XLEN*win +: XLEN];
    sel.data   = mem_req_in_a_data_i[DATA_W*win +: DATA_W];
    sel.mask   = mem_req_in_a_mask_i[MASK_W*win +: MASK_W];
    sel.source = mem_req_in_a_source_i[A_SOURCE*win +: A_SOURCE];
  end

  // Output slot and pointer next state.
  always_comb begin
    out_valid_d = out_valid_q;
    slot_d      = slot_q;
    id_d        = id_q;
    rr_ptr_d    = rr_ptr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      slot_d      = sel;
      id_d        = win;
      rr_ptr_d    = (int'(win) == NUM_REQ - 1) ? '0 : win + ID_W'(1);
    end else if (ld) begin
      out_valid_d = 1'b0;
    end
  end

  // Credit reserved on accept, returned on response; a return with no credit out is an error.
  always_comb begin
    uf_d = uf_q || (mem_rsp_fire_i && rsp_bad);
    for (int i = 0; i < NUM_REQ; i++) begin
      logic inc, dec;
      cnt_d[i] = cnt_q[i];
      inc = accept && gnt[i];
      dec = mem_rsp_fire_i && (mem_rsp_src_id_i == ID_W'(i));
      if (inc && !dec) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec && !inc) begin
        if (cnt_q[i] == '0) uf_d = 1'b1;
        else                cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      slot_q      <= '0;
      id_q        <= '0;
      rr_ptr_q    <= '0;
      uf_q        <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      slot_q      <= slot_d;
      id_q        <= id_d;
      rr_ptr_q    <= rr_ptr_d;
      uf_q        <= uf_d;
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign mem_req_out_valid_o    = out_valid_q;
  assign mem_req_out_a_opcode_o = slot_q.opcode;
  assign mem_req_out_a_param_o  = slot_q.param;
  assign mem_req_out_a_addr_o   = slot_q.addr;
  assign mem_req_out_a_data_o   = slot_q.data;
  assign mem_req_out_a_mask_o   = slot_q.mask;
  assign mem_req_out_a_source_o = {id_q, slot_q.source};
  assign credit_underflow_o     = uf_q;

endmodule

// File: tb/tb_l1_mem_req_sched.sv
// Directed bench for l1_mem_req_sched with NUM_REQ=2, MAX_OUTSTANDING=2.
module tb_l1_mem_req_sched;
  import l1_mem_req_sched_pkg::*;

  localparam int NR  = 2;
  localparam int IDW = 1;
  localparam int MO  = 2;
  localparam int CW  = 2;
  localparam int SW  = IDW + A_SOURCE;
  localparam int VW  = 3 + 3 + XLEN + DATA_W + MASK_W + SW;

  localparam logic [7:0] T0  = 8'h11;
  localparam logic [7:0] T1  = 8'h2A;
  localparam logic [7:0] T0B = 8'h33;
  localparam logic [7:0] T1B = 8'h4C;

  logic                      clk, rst;
  logic [NR-1:0]             valid_i, ready_o;
  logic [NR*3-1:0]           opcode_i, param_i;
  logic [NR*XLEN-1:0]        addr_i;
  logic [NR*DATA_W-1:0]      data_i;
  logic [NR*MASK_W-1:0]      mask_i;
  logic [NR*A_SOURCE-1:0]    source_i;
  logic                      out_valid, out_ready;
  logic [2:0]                opcode_o, param_o;
  logic [XLEN-1:0]           addr_o;
  logic [DATA_W-1:0]         data_o;
  logic [MASK_W-1:0]         mask_o;
  logic [SW-1:0]             source_o;
  logic                      rsp_fire;
  logic [IDW-1:0]            rsp_id;
  logic                      uf;
  logic [VW-1:0]             out_vec;

  int vectors = 0;
  int miscompares = 0;

  l1_mem_req_sched #(.NUM_REQ(NR), .ID_W(IDW), .MAX_OUTSTANDING(MO), .CNT_W(CW)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .mem_req_in_valid_i     (valid_i),
    .mem_req_in_ready_o     (ready_o),
    .mem_req_in_a_opcode_i  (opcode_i),
    .mem_req_in_a_param_i   (param_i),
    .mem_req_in_a_addr_i    (addr_i),
    .mem_req_in_a_data_i    (data_i),
    .mem_req_in_a_mask_i    (mask_i),
    .mem_req_in_a_source_i  (source_i),
    .mem_req_out_valid_o    (out_valid),
    .mem_req_out_ready_i    (out_ready),
    .mem_req_out_a_opcode_o (opcode_o),
    .mem_req_out_a_param_o  (param_o),
    .mem_req_out_a_addr_o   (addr_o),
    .mem_req_out_a_data_o   (data_o),
    .mem_req_out_a_mask_o   (mask_o),
    .mem_req_out_a_source_o (source_o),
    .mem_rsp_fire_i         (rsp_fire),
    .mem_rsp_src_id_i       (rsp_id),
    .credit_underflow_o     (uf)
  );

  assign out_vec = {opcode_o, param_o, addr_o, data_o, mask_o, source_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] exp_out(input logic [IDW-1:0] id, input logic [7:0] tag);
    return {tag[2:0], tag[5:3], {24'hC0DE00, tag}, {8{tag}}, tag, id, tag[2:0] ^ 3'b101};
  endfunction

  task automatic drive_pay(input int i, input logic [7:0] tag);
    opcode_i[3*i +: 3]               = tag[2:0];
    param_i[3*i +: 3]                = tag[5:3];
    addr_i[XLEN*i +: XLEN]           = {24'hC0DE00, tag};
    data_i[DATA_W*i +: DATA_W]       = {8{tag}};
    mask_i[MASK_W*i +: MASK_W]       = tag;
    source_i[A_SOURCE*i +: A_SOURCE] = tag[2:0] ^ 3'b101;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; valid_i = '0; out_ready = 1'b0; rsp_fire = 1'b0; rsp_id = '0;
    opcode_i = '0; param_i = '0; addr_i = '0; data_i = '0; mask_i = '0; source_i = '0;
    drive_pay(0, T0);
    drive_pay(1, T1);
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_payload", out_vec, 0);
    chk("rst_underflow", uf, 0);
    chk("rst_in_ready_idle", ready_o, 2'b00);
    valid_i = 2'b11; #1;
    chk("rst_in_ready_grant", ready_o, 2'b01);
    valid_i = 2'b00;
    tick;
    rst = 1'b0;

    // Fairness: both requesting, ready high, each request answered the next cycle.
    valid_i = 2'b11; out_ready = 1'b1; #1;
    chk("fair_pre_ready", ready_o, 2'b01);
    for (int k = 0; k < 4; k++) begin
      tick;
      rsp_fire = 1'b1; rsp_id = IDW'(k % 2); #1;
      chk("fair_out_valid", out_valid, 1);
      chk("fair_out_payload", out_vec, exp_out(IDW'(k % 2), (k % 2) ? T1 : T0));
      chk("fair_in_ready", ready_o, (k % 2) ? 2'b01 : 2'b10);
    end
    valid_i = 2'b00;
    tick;
    rsp_fire = 1'b0; #1;
    chk("fair_drain", out_valid, 0);

    // Backpressure: slot holds while ready low even though inputs change.
    out_ready = 1'b0; valid_i = 2'b11; #1;
    chk("bp_pre_ready", ready_o, 2'b01);
    tick;
    chk("bp_load", out_vec, exp_out(1'b0, T0));
    chk("bp_in_ready_blocked", ready_o, 2'b00);
    drive_pay(0, T0B);
    drive_pay(1, T1B);
    for (int s = 0; s < 5; s++) begin
      tick;
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_payload", out_vec, exp_out(1'b0, T0));
      chk("bp_hold_in_ready", ready_o, 2'b00);
    end
    out_ready = 1'b1; #1;
    chk("bp_release_ready", ready_o, 2'b10);
    tick;
    chk("bp_next_winner", out_vec, exp_out(1'b1, T1B));
    valid_i = 2'b00; rsp_fire = 1'b1; rsp_id = 1'b0;
    tick;
    rsp_id = 1'b1;
    tick;
    rsp_fire = 1'b0; #1;
    chk("bp_drain", out_valid, 0);

    // Credit cap: cache 0 alone, no responses.
    valid_i = 2'b01; #1;
    chk("cap_pre_ready", ready_o, 2'b01);
    tick;
    chk("cap_accept1_ready", ready_o, 2'b01);
    chk("cap_accept1_payload", out_vec, exp_out(1'b0, T0B));
    tick;
    chk("cap_full_ready", ready_o, 2'b00);
    tick;
    chk("cap_full_ready_hold", ready_o, 2'b00);
    chk("cap_slot_drained", out_valid, 0);
    rsp_fire = 1'b1; rsp_id = 1'b0; #1;
    chk("cap_credit_not_comb", ready_o, 2'b00);
    tick;
    rsp_fire = 1'b0; #1;
    chk("cap_resume", ready_o, 2'b01);
    tick;
    chk("cap_full_again", ready_o, 2'b00);
    valid_i = 2'b00; rsp_fire = 1'b1; rsp_id = 1'b0;
    tick;
    tick;
    rsp_fire = 1'b0;

    // Simultaneous accept and response on id 1 leaves its count unchanged.
    valid_i = 2'b10; #1;
    chk("sim_pre_ready", ready_o, 2'b10);
    tick;
    chk("sim_cnt1_ready", ready_o, 2'b10);
    rsp_fire = 1'b1; rsp_id = 1'b1;
    tick;
    rsp_fire = 1'b0; #1;
    chk("sim_cnt_kept", ready_o, 2'b10);
    tick;
    chk("sim_now_full", ready_o, 2'b00);
    valid_i = 2'b00; rsp_fire = 1'b1; rsp_id = 1'b1;
    tick;
    tick;
    rsp_fire = 1'b0;

    // Underflow: response for id 0 with nothing outstanding.
    rsp_fire = 1'b1; rsp_id = 1'b0; #1;
    chk("uf_before", uf, 0);
    tick;
    rsp_fire = 1'b0; #1;
    chk("uf_set", uf, 1);
    valid_i = 2'b01; #1;
    chk("uf_pre_ready", ready_o, 2'b01);
    tick;
    chk("uf_cnt0_one", ready_o, 2'b01);
    tick;
    chk("uf_cnt0_stayed_zero", ready_o, 2'b00);
    chk("uf_sticky", uf, 1);
    valid_i = 2'b11; #1;
    chk("uf_ready_id1", ready_o, 2'b10);
    tick;
    out_ready = 1'b0; #1;
    chk("uf_sticky_traffic", uf, 1);
    chk("mid_out_valid", out_valid, 1);
    chk("mid_payload", out_vec, exp_out(1'b1, T1B));

    // Reset mid-traffic with cnt = {2,1} and a full slot.
    rst = 1'b1; #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_payload", out_vec, 0);
    chk("mid_rst_underflow", uf, 0);
    chk("mid_rst_ptr", ready_o, 2'b01);
    tick;
    rst = 1'b0;
    valid_i = 2'b10; out_ready = 1'b1; #1;
    chk("post_rst_ready1", ready_o, 2'b10);
    tick;
    chk("post_rst_cnt1_cleared", ready_o, 2'b10);
    tick;
    chk("post_rst_cnt1_full", ready_o, 2'b00);
    valid_i = 2'b01; #1;
    chk("post_rst_ready0", ready_o, 2'b01);
    tick;
    chk("post_rst_cnt0_cleared", ready_o, 2'b01);
    tick;
    chk("post_rst_cnt0_full", ready_o, 2'b00);
    chk("post_rst_underflow", uf, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
